// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the mm:ss countdown control stage.
//   state_t            : controller state encoding (IDLE/RUN/PAUSE/DONE)
//   DIV_COUNT_DEFAULT  : default number of system clocks per decrement strobe
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DIV_COUNT_DEFAULT = 100;

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Modulo-DIV_COUNT counter that paces the 1 Hz decrement strobe.
// Ports:
//   clock    in  system clock, rising edge
//   clrn     in  asynchronous active-low reset
//   i_clear  in  force count to 0 (highest priority)
//   i_run    in  advance count (wraps DIV_COUNT-1 -> 0); holds when low
//   o_wrap   out high while the count sits at DIV_COUNT-1
// DIV_COUNT must be at least 2; count width is clog2(DIV_COUNT).
// -----------------------------------------------------------------------------
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_COUNT = DIV_COUNT_DEFAULT
) (
    input  logic clock,
    input  logic clrn,
    input  logic i_clear,
    input  logic i_run,
    output logic o_wrap
);

    localparam int W = $clog2(DIV_COUNT);
    localparam logic [W-1:0] LAST = W'(DIV_COUNT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end

    assign o_wrap = (r_count == LAST);

endmodule

// File: rtl/timer_control.sv
// -----------------------------------------------------------------------------
// timer_control
// Control stage in front of the mm:ss down-counter chain. Turns one-cycle
// start/stop/load requests into a one-cycle active-low load strobe and a
// once-per-second decrement strobe, and detects expiry via timer_zero.
// Ports:
//   clock       in  system clock, rising edge
//   clrn        in  asynchronous active-low reset
//   start_req   in  start / resume request
//   stop_req    in  pause / abort request (highest priority)
//   load_req    in  load preset digits request
//   timer_zero  in  all counter digits are zero
//   loadn       out active-low load strobe (registered)
//   enable      out decrement strobe (registered)
//   running     out high while in RUN
//   done        out high while in DONE
//   alarm       out alarm indicator
// Optional feature macro: TIMER_ALARM_BLINK_EN
//   defined   : alarm blinks in DONE (toggles on every prescaler wrap, starts 1)
//   undefined : alarm follows done; prescaler idles in DONE
// -----------------------------------------------------------------------------
module timer_control
    import timer_pkg::*;
#(
    parameter int DIV_COUNT = DIV_COUNT_DEFAULT
) (
    input  logic clock,
    input  logic clrn,
    input  logic start_req,
    input  logic stop_req,
    input  logic load_req,
    input  logic timer_zero,
    output logic loadn,
    output logic enable,
    output logic running,
    output logic done,
    output logic alarm
);

    state_t r_state;
    logic   r_loadn;
    logic   r_enable;
    logic   r_running;
    logic   r_done;
    logic   r_alarm;

    state_t w_state_next;
    logic   w_loadn_next;
    logic   w_any_req;
    logic   w_go_done;
    logic   w_count_run;
    logic   w_resume;
    logic   w_advance;
    logic   w_fire;
    logic   w_wrap;
    logic   w_pre_clear;
    logic   w_pre_run;
    logic   w_done_blink;

    assign w_any_req = start_req | stop_req | load_req;

    // Expiry is only trusted when no decrement is in flight: during an enable
    // cycle the counters have not yet absorbed the strobe, so timer_zero is stale.
    assign w_go_done   = (r_state == RUN) && !stop_req && timer_zero && !r_enable;
    assign w_count_run = (r_state == RUN) && !stop_req && !w_go_done;
    // Resume edge counts as a running tick, so the held phase carries over.
    assign w_resume    = (r_state == PAUSE) && start_req && !stop_req && !load_req;
    assign w_advance   = w_count_run | w_resume;
    // Never strobe into an all-zero chain: that would wrap 00:00 to 59:59.
    assign w_fire      = w_advance && w_wrap && !timer_zero;

`ifdef TIMER_ALARM_BLINK_EN
    assign w_done_blink = (r_state == DONE) && !w_any_req;
`else
    assign w_done_blink = 1'b0;
`endif

    // Clearing on DONE entry gives the blink a clean 2*DIV_COUNT period.
    assign w_pre_clear = (r_state == IDLE)
                       || ((r_state == PAUSE) && (stop_req || load_req))
                       || w_go_done
                       || ((r_state == DONE) && w_any_req);
    assign w_pre_run   = w_advance | w_done_blink;

    timer_prescaler #(
        .DIV_COUNT (DIV_COUNT)
    ) u_prescaler (
        .clock   (clock),
        .clrn    (clrn),
        .i_clear (w_pre_clear),
        .i_run   (w_pre_run),
        .o_wrap  (w_wrap)
    );

    // Next-state decode; request priority is stop > load > start.
    always_comb begin
        w_state_next = r_state;
        w_loadn_next = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (!stop_req) begin
                    if (load_req) begin
                        w_loadn_next = 1'b0;
                    end else if (start_req && !timer_zero) begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (stop_req) begin
                    w_state_next = PAUSE;
                end else if (w_go_done) begin
                    w_state_next = DONE;
                end
            end
            PAUSE: begin
                if (stop_req) begin
                    w_state_next = IDLE;
                end else if (load_req) begin
                    w_state_next = IDLE;
                    w_loadn_next = 1'b0;
                end else if (start_req) begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (w_any_req) begin
                    w_state_next = IDLE;
                    w_loadn_next = !(load_req && !stop_req);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state   <= IDLE;
            r_loadn   <= 1'b1;
            r_enable  <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_loadn   <= w_loadn_next;
            r_enable  <= w_fire;
            r_running <= (w_state_next == RUN);
            r_done    <= (w_state_next == DONE);
`ifdef TIMER_ALARM_BLINK_EN
            if (w_state_next == DONE) begin
                r_alarm <= (r_state != DONE) ? 1'b1 : (w_wrap ? ~r_alarm : r_alarm);
            end else begin
                r_alarm <= 1'b0;
            end
`else
            r_alarm   <= (w_state_next == DONE);
`endif
        end
    end

    assign loadn   = r_loadn;
    assign enable  = r_enable;
    assign running = r_running;
    assign done    = r_done;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_timer_control.sv
// -----------------------------------------------------------------------------
// tb_timer_control
// Scoreboard bench for timer_control with DIV_COUNT = 4. The reference model
// tracks mode, elapsed running cycles and cycles spent in DONE, plus a
// seconds-remaining model of the downstream counter chain that drives
// timer_zero. Expected outputs are queued per clock; a monitor compares them.
// -----------------------------------------------------------------------------
module tb_timer_control;

    localparam int DIV = 4;

    logic clock = 1'b0;
    logic clrn = 1'b0;
    logic start_req = 1'b0;
    logic stop_req = 1'b0;
    logic load_req = 1'b0;
    logic timer_zero = 1'b1;
    logic loadn, enable, running, done, alarm;

    timer_control #(.DIV_COUNT(DIV)) dut (
        .clock      (clock),
        .clrn       (clrn),
        .start_req  (start_req),
        .stop_req   (stop_req),
        .load_req   (load_req),
        .timer_zero (timer_zero),
        .loadn      (loadn),
        .enable     (enable),
        .running    (running),
        .done       (done),
        .alarm      (alarm)
    );

    always #5 clock = ~clock;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

    mode_t m_mode = M_IDLE;
    int    m_elapsed = 0;       // running cycles since the countdown started
    int    m_done_cycles = 0;   // cycles spent in DONE since entry
    int    m_remaining = 0;     // seconds held by the counter chain
    int    m_preset = 0;        // preset seconds on the load inputs
    bit    m_loadn = 1'b1;
    bit    m_enable = 1'b0;

    logic [4:0] exp_q[$];
    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [4:0] model_outputs();
        logic a;
`ifdef TIMER_ALARM_BLINK_EN
        a = (m_mode == M_DONE) && (((m_done_cycles / DIV) % 2) == 0);
`else
        a = (m_mode == M_DONE);
`endif
        return {m_loadn, m_enable, (m_mode == M_RUN), (m_mode == M_DONE), a};
    endfunction

    // One second of running time elapses every DIV running cycles.
    function automatic bit run_tick(input bit tz);
        m_elapsed++;
        return ((m_elapsed % DIV) == 0) && !tz;
    endfunction

    task automatic model_step(input bit s, input bit p, input bit l, input bit tz);
        bit old_en, old_ld, nl, ne;
        old_en = m_enable;
        old_ld = m_loadn;
        nl = 1'b1;
        ne = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (!p) begin
                    if (l) nl = 1'b0;
                    else if (s && !tz) begin
                        m_mode = M_RUN;
                        m_elapsed = 0;
                    end
                end
            end
            M_RUN: begin
                if (p) m_mode = M_PAUSE;
                else if (tz && !old_en) begin
                    m_mode = M_DONE;
                    m_done_cycles = 0;
                end else ne = run_tick(tz);
            end
            M_PAUSE: begin
                if (p) m_mode = M_IDLE;
                else if (l) begin
                    m_mode = M_IDLE;
                    nl = 1'b0;
                end else if (s) begin
                    m_mode = M_RUN;
                    ne = run_tick(tz);
                end
            end
            M_DONE: begin
                if (s || p || l) begin
                    m_mode = M_IDLE;
                    if (l && !p) nl = 1'b0;
                end else m_done_cycles++;
            end
            default: m_mode = M_IDLE;
        endcase
        if (m_mode == M_IDLE) m_elapsed = 0;
        // Counter chain reacts to the strobes that were on the wires at this edge.
        if (old_en && m_remaining > 0) m_remaining--;
        if (!old_ld) m_remaining = m_preset;
        m_loadn = nl;
        m_enable = ne;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_elapsed = 0;
        m_done_cycles = 0;
        m_loadn = 1'b1;
        m_enable = 1'b0;
    endtask

    // Drive one cycle of requests, let the edge happen, queue the expectation.
    task automatic tick(input bit s, input bit p, input bit l);
        start_req = s;
        stop_req = p;
        load_req = l;
        timer_zero = (m_remaining == 0);
        if (s || p || l)
            $display("[TB] t=%0t req start=%0b stop=%0b load=%0b timer_zero=%0b preset=%0d",
                     $time, s, p, l, timer_zero, m_preset);
        @(posedge clock);
        model_step(s, p, l, timer_zero);
        exp_q.push_back(model_outputs());
        #1;
        start_req = 1'b0;
        stop_req = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if ({loadn, enable, running, done, alarm} !== 5'b10000) begin
            n_fail++;
            $display("FAIL %s t=%0t loadn/enable/running/done/alarm got %05b want 10000",
                     tag, $time, {loadn, enable, running, done, alarm});
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic async_reset();
        @(negedge clock);
        #2;
        clrn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check_reset_outputs("reset_hold");
        #1;
        clrn = 1'b1;
        model_reset();
    endtask

    // Monitor: every cycle the DUT presents a fresh output word.
    initial begin
        logic [4:0] exp_v;
        logic [4:0] act_v;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {loadn, enable, running, done, alarm};
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t loadn/enable/running/done/alarm got %05b want %05b",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        int r;
        bit s, p, l;

        // Power-on reset
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check_reset_outputs("power_on_reset");
        #1;
        clrn = 1'b1;
        model_reset();

        // No strobes out of reset; start with an empty chain is ignored
        idle(3);
        tick(1'b1, 1'b0, 1'b0);
        idle(3);

        // Load 2 s, run to expiry (enables at +4, +8; DONE two cycles later)
        m_preset = 2;
        tick(1'b0, 1'b0, 1'b1);
        idle(2);
        tick(1'b1, 1'b0, 1'b0);
        idle(14);
        tick(1'b1, 1'b0, 1'b0);      // DONE -> IDLE
        idle(3);

        // Load 5 s, run, pause at phase 1, long pause, resume
        m_preset = 5;
        tick(1'b0, 1'b0, 1'b1);
        idle(1);
        tick(1'b1, 1'b0, 1'b0);
        idle(5);
        tick(1'b0, 1'b1, 1'b0);
        idle(13);
        tick(1'b1, 1'b0, 1'b0);
        idle(6);

        // Stop and start together in PAUSE: stop wins, back to IDLE
        tick(1'b0, 1'b1, 1'b0);
        idle(2);
        tick(1'b1, 1'b1, 1'b0);
        idle(3);

        // Load while RUN is ignored; async reset mid-RUN
        tick(1'b1, 1'b0, 1'b0);
        idle(2);
        tick(1'b0, 1'b0, 1'b1);
        idle(3);
        async_reset();
        idle(6);

        // Load request in PAUSE, then load request in DONE
        m_preset = 1;
        tick(1'b0, 1'b0, 1'b1);
        idle(1);
        tick(1'b1, 1'b0, 1'b0);
        idle(2);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        idle(2);
        tick(1'b1, 1'b0, 1'b0);
        idle(16);
        tick(1'b0, 1'b0, 1'b1);
        idle(3);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            s = (r < 5) || (r >= 97);
            p = (r >= 5 && r < 8) || (r >= 98);
            l = (r >= 8 && r < 12) || (r == 99);
            if (l) m_preset = $urandom_range(0, 5);
            if ($urandom_range(0, 499) == 0) async_reset();
            else tick(s, p, l);
        end

        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
